// File: rtl/mem_write_arbiter.sv
// Two-source memory write arbiter: per-source FIFOs feeding a single registered
// output slot, with round-robin grant and a saturating drop counter.

module mem_write_arbiter_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_req,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         not_empty,
    output logic         full,
    output logic         dropped
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_next;
    logic          push;

    // full is registered, so a same-cycle pop never frees room for a push
    assign push      = wr_req && !full;
    assign dropped   = wr_req && full;
    assign not_empty = (count != '0);
    assign rd_data   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + (PW+1)'(1);
        end else if (pop && !push) begin
            count_next = count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_next;
            full  <= (count_next == (PW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
endmodule

// state     | meaning
// GRANT_FB  | framebuffer preferred for the next slot load
// GRANT_BVH | BVH preferred for the next slot load
module mem_write_arbiter #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fb_valid,
    input  logic [ADDR_W-1:0] fb_addr,
    input  logic [DATA_W-1:0] fb_data,
    output logic              fb_full,
    input  logic              bvh_valid,
    input  logic [ADDR_W-1:0] bvh_addr,
    input  logic [DATA_W-1:0] bvh_data,
    output logic              bvh_full,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_src,
    input  logic              mem_ready,
    output logic [15:0]       drop_count
);
    localparam int W = ADDR_W + DATA_W;

    typedef enum logic {GRANT_FB, GRANT_BVH} grant_t;

    grant_t       state;
    grant_t       state_next;
    logic         fb_pop;
    logic         bvh_pop;
    logic         fb_ne;
    logic         bvh_ne;
    logic         fb_drop;
    logic         bvh_drop;
    logic [W-1:0] fb_rd;
    logic [W-1:0] bvh_rd;
    logic [16:0]  drop_sum;

    mem_write_arbiter_fifo #(.DEPTH(DEPTH), .W(W)) u_fb_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_req    (fb_valid),
        .wr_data   ({fb_addr, fb_data}),
        .pop       (fb_pop),
        .rd_data   (fb_rd),
        .not_empty (fb_ne),
        .full      (fb_full),
        .dropped   (fb_drop)
    );

    mem_write_arbiter_fifo #(.DEPTH(DEPTH), .W(W)) u_bvh_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_req    (bvh_valid),
        .wr_data   ({bvh_addr, bvh_data}),
        .pop       (bvh_pop),
        .rd_data   (bvh_rd),
        .not_empty (bvh_ne),
        .full      (bvh_full),
        .dropped   (bvh_drop)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= GRANT_FB;
        else       state <= state_next;
    end

    // Serving the non-preferred source keeps the preference where it is
    always_comb begin
        state_next = state;
        fb_pop     = 1'b0;
        bvh_pop    = 1'b0;
        if (!mem_valid || mem_ready) begin
            if (state == GRANT_FB) begin
                if (fb_ne) begin
                    fb_pop     = 1'b1;
                    state_next = GRANT_BVH;
                end else if (bvh_ne) begin
                    bvh_pop = 1'b1;
                end
            end else begin
                if (bvh_ne) begin
                    bvh_pop    = 1'b1;
                    state_next = GRANT_FB;
                end else if (fb_ne) begin
                    fb_pop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            mem_src   <= 1'b0;
        end else if (fb_pop || bvh_pop) begin
            mem_valid            <= 1'b1;
            {mem_addr, mem_data} <= bvh_pop ? bvh_rd : fb_rd;
            mem_src              <= bvh_pop;
        end else if (mem_ready) begin
            mem_valid <= 1'b0;
        end
    end

    assign drop_sum = {1'b0, drop_count} + 17'(fb_drop) + 17'(bvh_drop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            drop_count <= '0;
        else if (drop_sum[16]) drop_count <= 16'hFFFF;
        else                  drop_count <= drop_sum[15:0];
    end
endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed bench for mem_write_arbiter: cycle table for arbitration/ordering,
// hand sequences for backpressure, full/pop collision, reset and saturation.

module tb_mem_write_arbiter;
    logic        clk;
    logic        reset;
    logic        fb_valid;
    logic [31:0] fb_addr;
    logic [31:0] fb_data;
    logic        fb_full;
    logic        bvh_valid;
    logic [31:0] bvh_addr;
    logic [31:0] bvh_data;
    logic        bvh_full;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_src;
    logic        mem_ready;
    logic [15:0] drop_count;

    int total;
    int passed;

    typedef struct {
        logic        fv;
        logic [31:0] fa;
        logic        bv;
        logic [31:0] ba;
        logic        rdy;
        logic        ev;
        logic [31:0] ea;
        logic        es;
    } vec_t;

    vec_t vecs[15];

    mem_write_arbiter #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .fb_valid   (fb_valid),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_full    (fb_full),
        .bvh_valid  (bvh_valid),
        .bvh_addr   (bvh_addr),
        .bvh_data   (bvh_data),
        .bvh_full   (bvh_full),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_src    (mem_src),
        .mem_ready  (mem_ready),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a * 32'h0101_0101;
    endfunction

    function automatic vec_t mk(input logic fv, input logic [31:0] fa,
                                input logic bv, input logic [31:0] ba,
                                input logic rdy, input logic ev,
                                input logic [31:0] ea, input logic es);
        vec_t v;
        v.fv = fv; v.fa = fa; v.bv = bv; v.ba = ba;
        v.rdy = rdy; v.ev = ev; v.ea = ea; v.es = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fb(input logic v, input logic [31:0] a);
        fb_valid = v;
        fb_addr  = a;
        fb_data  = data_of(a);
    endtask

    task automatic drive_bvh(input logic v, input logic [31:0] a);
        bvh_valid = v;
        bvh_addr  = a;
        bvh_data  = data_of(a);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_fb(1'b0, 32'h0);
        drive_bvh(1'b0, 32'h0);
        mem_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [31:0] exp27 [4];

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b1;
        drive_fb(1'b0, 32'h0);
        drive_bvh(1'b0, 32'h0);
        mem_ready = 1'b0;

        vecs[0]  = mk(1'b1, 32'h0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h0,  1'b0);
        vecs[1]  = mk(1'b1, 32'h1, 1'b1, 32'h11, 1'b1, 1'b1, 32'h0,  1'b0);
        vecs[2]  = mk(1'b1, 32'h2, 1'b1, 32'h12, 1'b1, 1'b1, 32'h10, 1'b1);
        vecs[3]  = mk(1'b1, 32'h3, 1'b1, 32'h13, 1'b1, 1'b1, 32'h1,  1'b0);
        vecs[4]  = mk(1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h11, 1'b1);
        vecs[5]  = mk(1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h2,  1'b0);
        vecs[6]  = mk(1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h12, 1'b1);
        vecs[7]  = mk(1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h3,  1'b0);
        vecs[8]  = mk(1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h13, 1'b1);
        vecs[9]  = mk(1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h13, 1'b0);
        vecs[10] = mk(1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h13, 1'b0);
        vecs[11] = mk(1'b1, 32'h30, 1'b1, 32'h21, 1'b1, 1'b1, 32'h20, 1'b1);
        vecs[12] = mk(1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h30, 1'b0);
        vecs[13] = mk(1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h21, 1'b1);
        vecs[14] = mk(1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h21, 1'b0);

        // Reset values
        tick();
        check("rst_mem_valid",  64'(mem_valid),  64'h0);
        check("rst_mem_addr",   64'(mem_addr),   64'h0);
        check("rst_mem_data",   64'(mem_data),   64'h0);
        check("rst_mem_src",    64'(mem_src),    64'h0);
        check("rst_fb_full",    64'(fb_full),    64'h0);
        check("rst_bvh_full",   64'(bvh_full),   64'h0);
        check("rst_drop_count", 64'(drop_count), 64'h0);
        reset = 1'b0;

        // Cycle table: interleaved order, fallback grant without toggle, drain
        for (int i = 0; i < 15; i++) begin
            drive_fb(vecs[i].fv, vecs[i].fa);
            drive_bvh(vecs[i].bv, vecs[i].ba);
            mem_ready = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d_valid", i), 64'(mem_valid), 64'(vecs[i].ev));
            check($sformatf("vec%0d_addr", i),  64'(mem_addr),  64'(vecs[i].ea));
            check($sformatf("vec%0d_data", i),  64'(mem_data),  64'(data_of(vecs[i].ea)));
            if (vecs[i].ev) check($sformatf("vec%0d_src", i), 64'(mem_src), 64'(vecs[i].es));
        end
        check("table_drops", 64'(drop_count), 64'h0);

        // Single fb request latency and one-cycle pulse
        do_reset();
        mem_ready = 1'b1;
        fb_valid  = 1'b1;
        fb_addr   = 32'h100;
        fb_data   = 32'hAABBCCDD;
        tick();
        fb_valid = 1'b0;
        check("single_c1_valid", 64'(mem_valid), 64'h0);
        tick();
        check("single_c2_valid", 64'(mem_valid), 64'h1);
        check("single_c2_addr",  64'(mem_addr),  64'h100);
        check("single_c2_data",  64'(mem_data),  64'hAABBCCDD);
        check("single_c2_src",   64'(mem_src),   64'h0);
        tick();
        check("single_c3_valid", 64'(mem_valid), 64'h0);

        // Backpressure: slot holds first entry, then 6 more offered, 2 dropped
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive_fb(1'b1, 32'h200 + 32'(i));
            tick();
            if (i == 3) check("bp_full_before", 64'(fb_full), 64'h0);
            if (i == 4) check("bp_full_after4", 64'(fb_full), 64'h1);
            if (i >= 1) begin
                check($sformatf("bp_hold_valid%0d", i), 64'(mem_valid), 64'h1);
                check($sformatf("bp_hold_addr%0d", i),  64'(mem_addr),  64'h200);
                check($sformatf("bp_hold_data%0d", i),  64'(mem_data),  64'(data_of(32'h200)));
            end
        end
        drive_fb(1'b0, 32'h0);
        check("bp_drop_count", 64'(drop_count), 64'h2);
        mem_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            check($sformatf("bp_drain_addr%0d", j), 64'(mem_addr), 64'(32'h201 + 32'(j)));
            check($sformatf("bp_drain_valid%0d", j), 64'(mem_valid), 64'h1);
        end
        check("bp_full_drained", 64'(fb_full), 64'h0);
        tick();
        check("bp_end_valid", 64'(mem_valid), 64'h0);

        // Full FIFO with simultaneous pop and offered push
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_fb(1'b1, 32'h300 + 32'(i));
            tick();
        end
        check("col_full_set", 64'(fb_full), 64'h1);
        check("col_slot_addr", 64'(mem_addr), 64'h300);
        mem_ready = 1'b1;
        drive_fb(1'b1, 32'h305);
        tick();
        check("col_drop_refused", 64'(drop_count), 64'h1);
        check("col_full_cleared", 64'(fb_full), 64'h0);
        check("col_slot_next", 64'(mem_addr), 64'h301);
        mem_ready = 1'b0;
        drive_fb(1'b1, 32'h306);
        tick();
        check("col_full_again", 64'(fb_full), 64'h1);
        check("col_drop_same", 64'(drop_count), 64'h1);
        drive_fb(1'b0, 32'h0);
        mem_ready = 1'b1;
        exp27[0] = 32'h302; exp27[1] = 32'h303; exp27[2] = 32'h304; exp27[3] = 32'h306;
        for (int j = 0; j < 4; j++) begin
            tick();
            check($sformatf("col_drain_addr%0d", j), 64'(mem_addr), 64'(exp27[j]));
        end
        tick();
        check("col_end_valid", 64'(mem_valid), 64'h0);

        // Asynchronous reset mid-operation
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_fb(1'b1, 32'h500 + 32'(i));
            tick();
        end
        drive_fb(1'b0, 32'h0);
        check("mid_pre_valid", 64'(mem_valid), 64'h1);
        check("mid_pre_drop",  64'(drop_count), 64'h1);
        check("mid_pre_full",  64'(fb_full), 64'h1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(mem_valid),  64'h0);
        check("mid_rst_addr",  64'(mem_addr),   64'h0);
        check("mid_rst_data",  64'(mem_data),   64'h0);
        check("mid_rst_src",   64'(mem_src),    64'h0);
        check("mid_rst_full",  64'(fb_full),    64'h0);
        check("mid_rst_drop",  64'(drop_count), 64'h0);
        tick();
        reset     = 1'b0;
        mem_ready = 1'b1;
        drive_fb(1'b1, 32'h600);
        drive_bvh(1'b1, 32'h610);
        tick();
        drive_fb(1'b0, 32'h0);
        drive_bvh(1'b0, 32'h0);
        check("post_c0_valid", 64'(mem_valid), 64'h0);
        tick();
        check("post_c1_addr", 64'(mem_addr), 64'h600);
        check("post_c1_src",  64'(mem_src),  64'h0);
        tick();
        check("post_c2_addr", 64'(mem_addr), 64'h610);
        check("post_c2_src",  64'(mem_src),  64'h1);
        tick();
        check("post_c3_valid", 64'(mem_valid), 64'h0);

        // Drop counter: double drops and saturation
        do_reset();
        drive_fb(1'b1, 32'h700);
        drive_bvh(1'b1, 32'h710);
        for (int i = 0; i < 4; i++) tick();
        check("sat_e3_drop", 64'(drop_count), 64'h0);
        check("sat_e3_bfull", 64'(bvh_full), 64'h1);
        tick();
        check("sat_e4_drop", 64'(drop_count), 64'h1);
        check("sat_e4_ffull", 64'(fb_full), 64'h1);
        tick();
        check("sat_e5_drop", 64'(drop_count), 64'h3);
        repeat (32765) @(posedge clk);
        #1;
        check("sat_fffd", 64'(drop_count), 64'hFFFD);
        tick();
        check("sat_ffff", 64'(drop_count), 64'hFFFF);
        tick();
        check("sat_hold1", 64'(drop_count), 64'hFFFF);
        repeat (3) tick();
        check("sat_hold2", 64'(drop_count), 64'hFFFF);
        drive_fb(1'b0, 32'h0);
        drive_bvh(1'b0, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
